// File: rtl/mul_share_arbiter.sv
// ============================================================================
// mul_share_arbiter
// ----------------------------------------------------------------------------
// Shares one external combinational W x W unsigned multiplier between two
// requesters. Picks a requester, registers its operands onto the multiplier
// and captures the 2W-bit product. The product goes back with the requester
// ID over a valid/ready response channel.
//
// When both requesters are valid, the one that did not win last time is
// picked. last_grant starts at 1, so requester 0 wins the first tie.
//
// One operation takes three states: IDLE (grant), CALC (multiply) and
// RESP (hold the result until the consumer accepts it). The arbiter takes
// no new operands while an operation is in flight.
//
// Optional feature (compile-time macro MUL_ARB_CNT_EN):
//   Adds parameter CNT_W and output port op_count. op_count counts completed
//   responses and wraps modulo 2^CNT_W. With the macro undefined, neither the
//   parameter, the port nor the counter exists.
//
// Parameters
//   W      operand width; the product is 2*W bits wide
//   CNT_W  op_count width (only with MUL_ARB_CNT_EN)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active-low
//   req0_valid  requester 0 has an operation
//   req0_ready  requester 0 operands accepted this cycle (combinational)
//   req0_a/b    requester 0 operands
//   req1_valid  requester 1 has an operation
//   req1_ready  requester 1 operands accepted this cycle (combinational)
//   req1_a/b    requester 1 operands
//   mul_a/b     registered operands driven to the shared multiplier
//   mul_out     product returned by the shared multiplier
//   rsp_valid   result available
//   rsp_ready   consumer accepts the result
//   rsp_data    registered product
//   rsp_id      requester that owns rsp_data
//   busy        high whenever the FSM is not in IDLE
//   op_count    completed operations (only with MUL_ARB_CNT_EN)
// ============================================================================
module mul_share_arbiter #(
    parameter int W = 4
`ifdef MUL_ARB_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*W-1:0]   rsp_data,
    output logic             rsp_id,
    output logic             busy
`ifdef MUL_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;     // requester granted most recently
    logic   grant_id_p0;    // owner of the operands now on mul_a/mul_b
    logic   grant0;
    logic   grant1;

    // Round-robin choice. This logic only looks at the valid lines. Gating
    // by state is done on the ready outputs and in the FSM.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // The readies stay low while reset is held, even when a requester is
    // already valid. The decode above gives at most one grant, so both
    // readies are never high together.
    assign req0_ready = rst_n && (state == IDLE) && grant0;
    assign req1_ready = rst_n && (state == IDLE) && grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_id_p0 <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_data    <= '0;
            rsp_id      <= 1'b0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                // ---- stage 0: grant and register the operands ----
                IDLE: begin
                    if (grant0 || grant1) begin
                        mul_a       <= grant1 ? req1_a : req0_a;
                        mul_b       <= grant1 ? req1_b : req0_b;
                        grant_id_p0 <= grant1;
                        last_grant  <= grant1;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                // ---- stage 1: capture the product ----
                // mul_a/mul_b stay unchanged. The next grant is the only
                // thing that updates them.
                CALC: begin
                    rsp_data  <= mul_out;
                    rsp_id    <= grant_id_p0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                // ---- stage 2: hold the response until it is accepted ----
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef MUL_ARB_CNT_EN
    // Counts accepted responses. The counter wraps on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
    localparam int W = 4;
`ifdef MUL_ARB_CNT_EN
    localparam int CNT_W = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] mul_a, mul_b;
    logic [2*W-1:0] mul_out;
    logic         rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic         rsp_id;
    logic         busy;
`ifdef MUL_ARB_CNT_EN
    logic [CNT_W-1:0] op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External shared multiplier
    assign mul_out = {4'b0, mul_a} * {4'b0, mul_b};

    mul_share_arbiter #(
        .W(W)
`ifdef MUL_ARB_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy)
`ifdef MUL_ARB_CNT_EN
        , .op_count(op_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard + cycle reference model ----------------
    typedef struct {
        logic         id;
        logic [3:0]   a;
        logic [3:0]   b;
        logic [7:0]   data;
    } exp_t;

    exp_t sb[$];
    int   m_state = 0;      // 0 idle, 1 calc, 2 resp
    logic m_last  = 1'b1;
`ifdef MUL_ARB_CNT_EN
    logic [CNT_W-1:0] m_cnt = '0;
`endif

    always @(negedge clk) begin : mon
        logic e0, e1;
        exp_t e;
        if (!rst_n) begin
            m_state = 0;
            m_last  = 1'b1;
            sb.delete();
            chk("mon_rst_busy",      32'(busy),       0);
            chk("mon_rst_rsp_valid", 32'(rsp_valid),  0);
            chk("mon_rst_ready0",    32'(req0_ready), 0);
            chk("mon_rst_ready1",    32'(req1_ready), 0);
`ifdef MUL_ARB_CNT_EN
            m_cnt = '0;
            chk("mon_rst_op_count", 32'(op_count), 0);
`endif
        end else begin
            e0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
            e1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
            chk("mon_ready0",    32'(req0_ready), 32'(e0));
            chk("mon_ready1",    32'(req1_ready), 32'(e1));
            chk("mon_busy",      32'(busy),       32'(m_state != 0));
            chk("mon_rsp_valid", 32'(rsp_valid),  32'(m_state == 2));
            if (m_state == 1 && sb.size() > 0) begin
                chk("mon_mul_a", 32'(mul_a), 32'(sb[0].a));
                chk("mon_mul_b", 32'(mul_b), 32'(sb[0].b));
            end
            if (m_state == 2 && sb.size() > 0) begin
                chk("mon_rsp_data", 32'(rsp_data), 32'(sb[0].data));
                chk("mon_rsp_id",   32'(rsp_id),   32'(sb[0].id));
            end
`ifdef MUL_ARB_CNT_EN
            chk("mon_op_count", 32'(op_count), 32'(m_cnt));
`endif
            case (m_state)
                0: if (e0 || e1) begin
                    e.id   = e1;
                    e.a    = e1 ? req1_a : req0_a;
                    e.b    = e1 ? req1_b : req0_b;
                    e.data = {4'b0, e.a} * {4'b0, e.b};
                    sb.push_back(e);
                    m_last  = e1;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    m_state = 0;
`ifdef MUL_ARB_CNT_EN
                    m_cnt = m_cnt + 1'b1;
`endif
                end
            endcase
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       v0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       v1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       exp_id;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[6];

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rsp_valid", 32'(rsp_valid), 1);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk); #1;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk("vec_ready0", 32'(req0_ready), 32'(v.exp_id == 1'b0));
        chk("vec_ready1", 32'(req1_ready), 32'(v.exp_id == 1'b1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("vec_calc_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("vec_rsp_valid", 32'(rsp_valid), 1);
        chk("vec_rsp_data",  32'(rsp_data),  32'(v.exp_data));
        chk("vec_rsp_id",    32'(rsp_id),    32'(v.exp_id));
        wait_idle(20);
    endtask

    logic       cont_id[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] cont_data[4] = '{8'd14, 8'd16, 8'd14, 8'd16};
`ifdef MUL_ARB_CNT_EN
    logic [CNT_W-1:0] cnt_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b0;

        vt[0] = '{1'b1, 4'd3,  4'd5,  1'b0, 4'd0,  4'd0,  1'b0, 8'd15};
        vt[1] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd15, 4'd15, 1'b1, 8'd225};
        vt[2] = '{1'b1, 4'd0,  4'd9,  1'b0, 4'd0,  4'd0,  1'b0, 8'd0};
        vt[3] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd1,  4'd13, 1'b1, 8'd13};
        vt[4] = '{1'b1, 4'd15, 4'd1,  1'b0, 4'd0,  4'd0,  1'b0, 8'd15};
        vt[5] = '{1'b0, 4'd0,  4'd0,  1'b1, 4'd12, 4'd10, 1'b1, 8'd120};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        chk("reset_mul_a",     32'(mul_a),     0);
        chk("reset_mul_b",     32'(mul_b),     0);
        chk("reset_rsp_data",  32'(rsp_data),  0);
        chk("reset_rsp_id",    32'(rsp_id),    0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy",      32'(busy),      0);

        // Single operations, including the max-operand case
        for (int i = 0; i < 6; i++) apply_vec(vt[i]);

        // Contention: both valid continuously, last grant was requester 1
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd7;
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(10);
            chk("cont_rsp_id",   32'(rsp_id),   32'(cont_id[k]));
            chk("cont_rsp_data", 32'(rsp_data), 32'(cont_data[k]));
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(20);

        // Back-pressure: RESP is held while req1 is offered, then withdrawn
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
        @(negedge clk);
        chk("bp_accept_ready0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(10);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            req1_valid = (c < 5); req1_a = 4'd9; req1_b = 4'd9;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid),  1);
            chk("bp_rsp_data",  32'(rsp_data),   42);
            chk("bp_rsp_id",    32'(rsp_id),     0);
            chk("bp_ready0",    32'(req0_ready), 0);
            chk("bp_ready1",    32'(req1_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("bp_release_rsp_valid", 32'(rsp_valid),  1);
        chk("bp_release_ready1",    32'(req1_ready), 0);
        @(negedge clk);
        chk("bp_next_grant_ready1", 32'(req1_ready), 1);
        chk("bp_next_rsp_valid",    32'(rsp_valid),  0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_rsp(10);
        chk("bp_second_data", 32'(rsp_data), 81);
        wait_idle(20);

        // Reset in the middle of CALC
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        @(negedge clk);
        chk("rmid_ready0", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rmid_mul_a",     32'(mul_a),      0);
        chk("rmid_mul_b",     32'(mul_b),      0);
        chk("rmid_rsp_data",  32'(rsp_data),   0);
        chk("rmid_rsp_id",    32'(rsp_id),     0);
        chk("rmid_rsp_valid", 32'(rsp_valid),  0);
        chk("rmid_busy",      32'(busy),       0);
        chk("rmid_ready0",    32'(req0_ready), 0);
        chk("rmid_ready1",    32'(req1_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rmid_no_rsp",  32'(rsp_valid), 0);
            chk("rmid_no_busy", 32'(busy),      0);
        end
        // last_grant must be back at 1, so requester 0 wins a tie
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
        @(negedge clk);
        chk("rmid_tie_ready0", 32'(req0_ready), 1);
        chk("rmid_tie_ready1", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(20);

`ifdef MUL_ARB_CNT_EN
        // Counter wrap with CNT_W = 2
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_a = 4'(k + 1); req0_b = 4'd3;
            @(negedge clk);
            chk("cnt_ready0", 32'(req0_ready), 1);
            @(posedge clk); #1;
            req0_valid = 1'b0;
            wait_idle(20);
            chk("cnt_op_count", 32'(op_count), 32'(cnt_exp[k]));
        end
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
